// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch FSM with ack timeout
// Optional misaligned-PC fault check enabled by defining FETCH_ALIGN_CHECK_EN.
module instruction_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_PC,
  input  logic        i_start,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_ack,
  output logic [31:0] o_instr,
  output logic        o_instr_DV,
  input  logic        i_instr_consumed,
  output logic        o_load_PC,
  output logic        o_busy,
  output logic        o_timeout,
  output logic        o_fault
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_REQ   = 2'd1;
  localparam logic [1:0]  ST_VALID = 2'd2;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [15:0] cnt_q;
  logic [31:0] instr_q;
  logic        load_q;
  logic        tmo_q;
  logic        fault_q;
  logic        misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = |i_PC[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      addr_q  <= 32'h0;
      cnt_q   <= 16'h0;
      instr_q <= 32'h0;
      load_q  <= 1'b0;
      tmo_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      load_q  <= 1'b0;
      tmo_q   <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            if (misaligned) begin
              fault_q <= 1'b1;
            end else begin
              addr_q <= i_PC;
              cnt_q  <= 16'h0;
              state  <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // an ack on the final allowed cycle wins over the timeout
          if (i_mem_ack) begin
            instr_q <= i_mem_data;
            state   <= ST_VALID;
          end else if (cnt_q == TMO_LAST) begin
            tmo_q <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_VALID: begin
          if (i_instr_consumed) begin
            load_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_rd   = (state == ST_REQ);
  assign o_mem_addr = o_mem_rd ? addr_q : 32'h0;
  assign o_instr    = instr_q;
  assign o_instr_DV = (state == ST_VALID);
  assign o_busy     = (state != ST_IDLE);
  assign o_load_PC  = load_q;
  assign o_timeout  = tmo_q;
  assign o_fault    = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
// Honours FETCH_ALIGN_CHECK_EN to select the expected misaligned-PC behaviour.
module tb_instruction_fetch;

  localparam int TMO = 4;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_PC;
  logic        i_start;
  logic [31:0] o_mem_addr;
  logic        o_mem_rd;
  logic [31:0] i_mem_data;
  logic        i_mem_ack;
  logic [31:0] o_instr;
  logic        o_instr_DV;
  logic        i_instr_consumed;
  logic        o_load_PC;
  logic        o_busy;
  logic        o_timeout;
  logic        o_fault;

  always #5 i_clk = ~i_clk;

  instruction_fetch #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_PC             (i_PC),
    .i_start          (i_start),
    .o_mem_addr       (o_mem_addr),
    .o_mem_rd         (o_mem_rd),
    .i_mem_data       (i_mem_data),
    .i_mem_ack        (i_mem_ack),
    .o_instr          (o_instr),
    .o_instr_DV       (o_instr_DV),
    .i_instr_consumed (i_instr_consumed),
    .o_load_PC        (o_load_PC),
    .o_busy           (o_busy),
    .o_timeout        (o_timeout),
    .o_fault          (o_fault)
  );

  int checks = 0;
  int failures = 0;
  int load_cnt = 0;
  bit cmp_en = 1'b0;

  // expected outputs for the current cycle, set by the driver from transaction intent
  logic [31:0] e_addr, e_instr;
  logic        e_rd, e_dv, e_load, e_busy, e_tmo, e_fault;
  logic [31:0] mem [0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_idle();
    e_rd = 0; e_addr = 0; e_dv = 0; e_instr = 0;
    e_load = 0; e_busy = 0; e_tmo = 0; e_fault = 0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("mem_rd", 32'(o_mem_rd), 32'(e_rd));
      chk("mem_addr", o_mem_addr, e_addr);
      chk("instr_dv", 32'(o_instr_DV), 32'(e_dv));
      chk("busy", 32'(o_busy), 32'(e_busy));
      chk("load_pc", 32'(o_load_PC), 32'(e_load));
      chk("timeout", 32'(o_timeout), 32'(e_tmo));
      chk("fault", 32'(o_fault), 32'(e_fault));
      if (e_dv) chk("instr", o_instr, e_instr);
      if (o_load_PC) load_cnt++;
    end
  end

  // One fetch: ack arrives on REQ cycle index `delay` (>= TMO means never), consumer holds `hold` cycles.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int delay,
                       input int hold, output bit ok);
    int n_req;
    ok = 1'b0;
    expect_idle();
    i_PC = pc; i_start = 1'b1;
    step();
    i_PC = $urandom;
    i_start = 1'b0;
    if (ALIGN_EN && pc[1:0] != 2'b00) begin
      expect_idle(); e_fault = 1'b1;
      step();
      expect_idle();
      return;
    end
    n_req = (delay < TMO) ? delay + 1 : TMO;
    for (int k = 0; k < n_req; k++) begin
      expect_idle(); e_rd = 1'b1; e_addr = pc; e_busy = 1'b1;
      i_mem_ack = (k == delay);
      i_mem_data = (k == delay) ? data : $urandom;
      i_start = 1'($urandom_range(0, 1));
      i_instr_consumed = 1'($urandom_range(0, 1));
      step();
    end
    i_mem_ack = 1'b0; i_instr_consumed = 1'b0;
    if (delay < TMO) begin
      for (int h = 0; h <= hold; h++) begin
        expect_idle(); e_dv = 1'b1; e_instr = data; e_busy = 1'b1;
        i_instr_consumed = (h == hold);
        i_mem_data = $urandom;
        i_mem_ack = 1'($urandom_range(0, 1));
        i_start = 1'($urandom_range(0, 1));
        step();
      end
      expect_idle(); e_load = 1'b1; ok = 1'b1;
    end else begin
      expect_idle(); e_tmo = 1'b1;
    end
    i_start = 1'b0; i_instr_consumed = 1'b0; i_mem_ack = 1'b0;
    step();
    expect_idle();
  endtask

  initial begin
    bit ok;
    int base;
    int tries;
    i_rst_n = 1'b0; i_PC = 0; i_start = 0; i_mem_data = 0; i_mem_ack = 0; i_instr_consumed = 0;
    expect_idle();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    #12;
    chk("rst_mem_rd", 32'(o_mem_rd), 32'h0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_dv", 32'(o_instr_DV), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_pulses", {29'd0, o_load_PC, o_timeout, o_fault}, 32'h0);
    step();
    i_rst_n = 1'b1; cmp_en = 1'b1;
    step();

    // basic fetch with minimum latency, literal expectations
    expect_idle(); i_PC = 32'h100; i_start = 1'b1;
    step();
    i_start = 1'b0;
    expect_idle(); e_rd = 1; e_addr = 32'h100; e_busy = 1;
    chk("lit_rd_n1", 32'(o_mem_rd), 32'h1);
    chk("lit_addr_n1", o_mem_addr, 32'h100);
    i_mem_ack = 1'b1; i_mem_data = 32'h00500093;
    step();
    i_mem_ack = 1'b0;
    expect_idle(); e_dv = 1; e_instr = 32'h00500093; e_busy = 1;
    chk("lit_dv_n2", 32'(o_instr_DV), 32'h1);
    chk("lit_instr_n2", o_instr, 32'h00500093);
    i_instr_consumed = 1'b1;
    step();
    i_instr_consumed = 1'b0;
    expect_idle(); e_load = 1;
    chk("lit_load", 32'(o_load_PC), 32'h1);
    chk("lit_dv_clr", 32'(o_instr_DV), 32'h0);
    step();
    expect_idle();
    chk("lit_load_once", 32'(o_load_PC), 32'h0);

    // backpressure: ten cycles of no consume with toggling data
    fetch(32'h200, 32'hCAFE0013, 1, 10, ok);
    chk("bp_ok", 32'(ok), 32'h1);

    // timeout with no ack, then ack on the final allowed cycle
    fetch(32'h240, 32'h0, TMO, 0, ok);
    chk("tmo_no_ack", 32'(ok), 32'h0);
    fetch(32'h244, 32'h12345678, TMO - 1, 0, ok);
    chk("tmo_edge_ack", 32'(ok), 32'h1);

    // reset during REQ, then a stale ack after release
    expect_idle(); i_PC = 32'h300; i_start = 1'b1;
    step();
    i_start = 1'b0;
    expect_idle(); e_rd = 1; e_addr = 32'h300; e_busy = 1;
    step();
    #1; i_rst_n = 1'b0; expect_idle();
    #1;
    chk("mid_rst_rd", 32'(o_mem_rd), 32'h0);
    chk("mid_rst_addr", o_mem_addr, 32'h0);
    chk("mid_rst_busy", 32'(o_busy), 32'h0);
    chk("mid_rst_instr", o_instr, 32'h0);
    step();
    i_rst_n = 1'b1; i_mem_ack = 1'b1; i_mem_data = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) step();
    i_mem_ack = 1'b0;
    chk("late_ack_instr", o_instr, 32'h0);

    // misaligned PC
    fetch(32'h102, 32'hABCD0001, 0, 0, ok);
    chk("align_ok", 32'(ok), ALIGN_EN ? 32'h0 : 32'h1);

    // back-to-back fetches, retrying any that time out
    base = load_cnt;
    for (int i = 0; i < 10; i++) begin
      tries = 0;
      do begin
        fetch(32'(i * 4), mem[i], $urandom_range(0, 5), $urandom_range(0, 2), ok);
        tries++;
      end while (!ok && tries < 30);
      if (!ok) chk("b2b_retry_bound", 32'(tries), 32'h0);
    end
    step();
    chk("b2b_loads", 32'(load_cnt - base), 32'd10);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of REQ-state cycles waited for i_mem_ack (legal range 1..65535).
REQ-002 i_clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 i_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 i_PC  input  32  SHALL carry the current program counter, sampled on fetch start.
REQ-005 i_start  input  1  SHALL request a fetch of the instruction at i_PC.
REQ-006 o_mem_addr  output  32  SHALL carry the instruction memory read address.
REQ-007 o_mem_rd  output  1  SHALL be the memory read strobe.
REQ-008 i_mem_data  input  32  SHALL carry the read data, valid when i_mem_ack=1.
REQ-009 i_mem_ack  input  1  SHALL indicate that memory read data is valid.
REQ-010 o_instr  output  32  SHALL carry the fetched instruction word.
REQ-011 o_instr_DV  output  1  SHALL indicate that o_instr is valid.
REQ-012 i_instr_consumed  input  1  SHALL indicate that the downstream decoder has accepted o_instr.
REQ-013 o_load_PC  output  1  SHALL be a one-cycle pulse to the program counter to advance or jump.
REQ-014 o_busy  output  1  SHALL be 1 whenever the state is not IDLE.
REQ-015 o_timeout  output  1  SHALL be a one-cycle pulse on fetch timeout.
REQ-016 o_fault  output  1  SHALL be a one-cycle pulse on a misaligned fetch (see Configuration).

Function
REQ-017 The FSM SHALL have the states IDLE, REQ and VALID.
REQ-018 IDLE, i_start=1: the block SHALL latch i_PC into an address register, clear the timeout counter and go to REQ.
REQ-019 REQ: o_mem_rd SHALL be 1 and o_mem_addr SHALL equal the latched PC, held stable until exit from REQ.
REQ-020 REQ, i_mem_ack=1: the block SHALL capture i_mem_data into o_instr and go to VALID; o_instr_DV SHALL be 1 from the next cycle.
REQ-021 Minimum latency: i_start at cycle N and i_mem_ack at N+1 SHALL give o_instr_DV=1 at N+2.
REQ-022 REQ, no ack: the 16-bit counter SHALL increment each cycle; when it equals TIMEOUT_CYCLES-1 with i_mem_ack=0, the block SHALL pulse o_timeout, deassert o_mem_rd and return to IDLE.
REQ-023 An ack arriving in the same cycle the timeout condition is met SHALL take priority (capture, no timeout).
REQ-024 VALID: o_instr and o_instr_DV=1 SHALL hold unchanged until i_instr_consumed=1.
REQ-025 VALID, i_instr_consumed=1: the block SHALL pulse o_load_PC for exactly one cycle, clear o_instr_DV and return to IDLE.
REQ-026 i_start SHALL be ignored outside IDLE; i_mem_ack SHALL be ignored outside REQ; i_instr_consumed SHALL be ignored outside VALID.
REQ-027 i_start asserted in the cycle after the o_load_PC pulse SHALL start a new fetch using the updated i_PC.
REQ-028 o_mem_addr SHALL be 0 whenever the state is not REQ.

Reset
REQ-029 Assertion of i_rst_n=0 SHALL immediately force IDLE, clear the counter and the address register, and drive every output to 0 (o_instr=32'h0), including mid-fetch.
REQ-030 After reset deassertion, a pending i_mem_ack SHALL be ignored until a new i_start.

Configuration
REQ-031 With FETCH_ALIGN_CHECK_EN defined: i_start in IDLE with i_PC[1:0]!=2'b00 SHALL pulse o_fault, issue no request and remain IDLE.
REQ-032 Without FETCH_ALIGN_CHECK_EN: o_fault SHALL be constant 0 and misaligned PCs SHALL be fetched unchanged.

Verification
REQ-033 Basic: i_PC=32'h100, i_start, ack one cycle later with data 32'h00500093 -> o_instr=32'h00500093, o_instr_DV at N+2; i_instr_consumed -> single o_load_PC pulse, back to IDLE.
REQ-034 Backpressure: hold i_instr_consumed=0 for 10 cycles, toggle i_mem_data -> o_instr stable and o_instr_DV=1 throughout; no o_load_PC.
REQ-035 Timeout: TIMEOUT_CYCLES=4, no ack -> o_mem_rd high for 4 cycles, o_timeout pulse, IDLE, o_load_PC never asserted; ack on the 4th cycle -> capture, no timeout.
REQ-036 Reset mid-fetch: i_rst_n low during REQ -> all outputs 0 asynchronously; a late ack after release -> no o_instr_DV.
REQ-037 Alignment: i_PC=32'h102 with FETCH_ALIGN_CHECK_EN -> o_fault pulse, o_mem_rd stays 0; without the macro -> o_mem_addr=32'h102, o_fault=0.
REQ-038 Back-to-back: ten fetches at PCs 0,4,...,36 with the ack delay randomized 0-5 cycles -> ten o_load_PC pulses, each o_instr matching the memory model.
